muldiv_sequencer: RTL and testbench

Multi-cycle controller for the M-extension ALU operations (ALU_MUL, ALU_MULH, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU). Sits beside the execute-stage ALU: accepts one operation from EX via valid/ready, sequences a registered multiply or a 32-iteration restoring divider, applies RISC-V corner-case rules, and returns the result with its write-back register id. `busy` is the execute-stage stall request.

---
 rtl/muldiv_sequencer_if.sv | 28 ++
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> M-extension sequencer handshake bundle.
// The sequencer takes the slave side; the execute stage drives the master side.
interface muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_id;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      out_rd_id;
    logic            busy;

    modport slave (
        input  in_valid, alu_op, op_a, op_b, rd_id, flush, out_ready,
        output in_ready, out_valid, result, out_rd_id, busy
    );

    modport master (
        output in_valid, alu_op, op_a, op_b, rd_id, flush, out_ready,
        input  in_ready, out_valid, result, out_rd_id, busy
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/MULH and 32-step restoring DIV/DIVU/REM/REMU controller with
// RISC-V divide-by-zero and signed-overflow results.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam logic [4:0] OpMul  = 5'b01110;
    localparam logic [4:0] OpMulh = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpDivu = 5'b10001;
    localparam logic [4:0] OpRem  = 5'b10010;
    localparam logic [4:0] OpRemu = 5'b10011;

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;

    logic            in_mul, in_div, in_signed, accept, in_dz, in_ovf;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   trial;
    logic [2*XLEN-1:0] prod;
    logic            op_is_rem;

    assign in_mul    = (bus.alu_op == OpMul) || (bus.alu_op == OpMulh);
    assign in_div    = (bus.alu_op == OpDiv) || (bus.alu_op == OpDivu) ||
                       (bus.alu_op == OpRem) || (bus.alu_op == OpRemu);
    assign in_signed = ~bus.alu_op[0];
    assign accept    = (state_q == StIdle) && bus.in_valid && !bus.flush && (in_mul || in_div);
    assign in_dz     = (bus.op_b == '0);
    assign in_ovf    = in_signed && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
    assign a_abs     = (in_signed && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
    assign b_abs     = (in_signed && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
    assign op_is_rem = op_q[1];

    // Remainder is always below the divisor, so one extra bit covers the shifted trial.
    assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, b_q};
    assign prod  = $signed({{XLEN{a_q[XLEN-1]}}, a_q}) * $signed({{XLEN{b_q[XLEN-1]}}, b_q});

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d = bus.alu_op;
                    rd_d = bus.rd_id;
                    a_d  = bus.op_a;
                    if (in_mul) begin
                        b_d     = bus.op_b;
                        state_d = StMul;
                    end else begin
                        b_d       = b_abs;
                        quo_d     = a_abs;
                        rem_d     = '0;
                        cnt_d     = '0;
                        dz_d      = in_dz;
                        ovf_d     = in_ovf;
                        neg_quo_d = in_signed && (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]);
                        neg_rem_d = in_signed && bus.op_a[XLEN-1];
                        state_d   = (in_dz || in_ovf) ? StFix : StDiv;
                    end
                end
            end
            StMul: begin
                result_d = (op_q == OpMulh) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
                state_d  = StDone;
            end
            StDiv: begin
                if (!trial[XLEN]) begin
                    rem_d = trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = StFix;
            end
            StFix: begin
                if (dz_q) begin
                    result_d = op_is_rem ? a_q : '1;
                end else if (ovf_q) begin
                    result_d = op_is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                end else if (op_is_rem) begin
                    result_d = neg_rem_q ? -rem_q : rem_q;
                end else begin
                    result_d = neg_quo_q ? -quo_q : quo_q;
                end
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (bus.flush && (state_q != StIdle)) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.out_rd_id = rd_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: latency, results, corner cases,
// back-pressure, flush and mid-operation reset.
module tb_muldiv_sequencer;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpMul  = 5'b01110;
    localparam logic [4:0] OpMulh = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpDivu = 5'b10001;
    localparam logic [4:0] OpRem  = 5'b10010;
    localparam logic [4:0] OpRemu = 5'b10011;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    muldiv_sequencer_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.rd_id    = rd;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Accept edge counts as cycle 1; latency is the edge count until out_valid is seen.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        issue(op, a, b, rd);
        check({tag, " busy_rise"}, {31'd0, bus.busy}, 32'd1);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, bus.result, exp_res);
        check({tag, " rd"}, {27'd0, bus.out_rd_id}, {27'd0, rd});
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " busy_fall"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, " result"}, bus.result, 32'd0);
        check({tag, " out_rd_id"}, {27'd0, bus.out_rd_id}, 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_op    = '0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.rd_id     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul", OpMul, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 2);
        run_op("mulh", OpMulh, 32'd7, 32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFFF, 2);
        run_op("div", OpDiv, 32'hFFFF_FFEC, 32'd3, 5'd3, 32'hFFFF_FFFA, 34);
        run_op("rem", OpRem, 32'hFFFF_FFEC, 32'd3, 5'd4, 32'hFFFF_FFFE, 34);
        run_op("rem_negb", OpRem, 32'd20, 32'hFFFF_FFFD, 5'd5, 32'd2, 34);
        run_op("divu", OpDivu, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'h7FFF_FFFF, 34);
        run_op("remu", OpRemu, 32'd100, 32'd7, 5'd7, 32'd2, 34);
        run_op("divu_dz", OpDivu, 32'h0000_1234, 32'd0, 5'd8, 32'hFFFF_FFFF, 2);
        run_op("remu_dz", OpRemu, 32'h0000_1234, 32'd0, 5'd9, 32'h0000_1234, 2);
        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 2);
        run_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 2);

        // Back-pressure: result held, new request ignored while DONE.
        issue(OpMul, 32'd6, 32'd7, 5'd13);
        @(posedge clk);
        #1;
        check("hold entry out_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b1;
        bus.alu_op   = OpDivu;
        bus.op_a     = 32'd99;
        bus.op_b     = 32'd3;
        bus.rd_id    = 5'd20;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold result", bus.result, 32'd42);
            check("hold rd", {27'd0, bus.out_rd_id}, 32'd13);
            check("hold in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold no_ghost busy", {31'd0, bus.busy}, 32'd0);
        check("hold no_ghost out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Flush while idle suppresses the accept.
        bus.flush = 1'b1;
        issue(OpMul, 32'd2, 32'd3, 5'd14);
        bus.flush = 1'b0;
        check("idle_flush busy", {31'd0, bus.busy}, 32'd0);

        // Flush mid-divide.
        issue(OpDiv, 32'd100, 32'd7, 5'd15);
        repeat (14) @(posedge clk);
        #1;
        check("flush pre busy", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush busy", {31'd0, bus.busy}, 32'd0);
        check("flush in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) check("flush spurious out_valid", 32'd1, 32'd0);
        end
        check("flush quiet out_valid", {31'd0, bus.out_valid}, 32'd0);
        run_op("divu_after_flush", OpDivu, 32'd100, 32'd7, 5'd12, 32'd14, 34);

        // Asynchronous reset mid-divide.
        issue(OpDiv, 32'hFFFF_FFEC, 32'd3, 5'd21);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Non-M op codes are not requests.
        bus.in_valid = 1'b1;
        bus.alu_op   = OpAdd;
        bus.op_a     = 32'd1;
        bus.op_b     = 32'd2;
        bus.rd_id    = 5'd22;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("alu_add busy", {31'd0, bus.busy}, 32'd0);
        end
        bus.in_valid = 1'b0;
        check("alu_add in_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
